// File: rtl/diff_commit_packer.sv
// Commit staging buffer for difftest: compacts sparse retire slots into a FIFO,
// drains up to NOUT in-order commits per cycle and orders exceptions after them.
module diff_commit_packer #(
  parameter int NCOMMIT = 3,
  parameter int NOUT    = 2,
  parameter int DEPTH   = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NCOMMIT-1:0]      in_valid,
  input  logic [64*NCOMMIT-1:0]   in_pc,
  input  logic [32*NCOMMIT-1:0]   in_instr,
  input  logic [NCOMMIT-1:0]      in_wen,
  input  logic [8*NCOMMIT-1:0]    in_wdest,
  input  logic [64*NCOMMIT-1:0]   in_wdata,
  output logic                    in_ready,
  input  logic                    excp_in_valid,
  input  logic                    excp_in_eret,
  input  logic [5:0]              excp_in_cause,
  input  logic [31:0]             excp_in_pc,
  output logic [NOUT-1:0]         out_valid,
  output logic [8*NOUT-1:0]       out_index,
  output logic [64*NOUT-1:0]      out_pc,
  output logic [32*NOUT-1:0]      out_instr,
  output logic [NOUT-1:0]         out_wen,
  output logic [8*NOUT-1:0]       out_wdest,
  output logic [64*NOUT-1:0]      out_wdata,
  output logic                    excp_valid,
  output logic                    excp_eret,
  output logic [5:0]              excp_cause,
  output logic [31:0]             excp_pc,
  output logic                    overflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        wen;
    logic [7:0]  wdest;
    logic [63:0] wdata;
  } ent_t;

  typedef enum logic [1:0] {
    EX_IDLE,
    EX_WAIT,
    EX_FIRE
  } ex_e;

  ent_t            mem_q [DEPTH];
  ent_t            ent_q [NOUT];
  logic [NOUT-1:0] vld_q;

  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] n_all, n_push, pop;
  logic [AW-1:0] waddr [NCOMMIT];
  logic          acc;
  logic          ovf_q, ovf_d;
  ex_e           st_q, st_d;

  logic          eret_q;
  logic [5:0]    cause_q;
  logic [31:0]   epc_q;

  assign in_ready = (cnt_q <= CW'(DEPTH - NCOMMIT)) && (st_q == EX_IDLE);
  assign acc      = in_ready && ((|in_valid) || excp_in_valid);

  // Valid slot i lands at wr + (number of valid slots below i).
  always_comb begin
    n_all = '0;
    for (int i = 0; i < NCOMMIT; i++) begin
      waddr[i] = wr_q + n_all[AW-1:0];
      if (in_valid[i]) n_all = n_all + 1'b1;
    end
  end

  always_comb begin
    n_push = acc ? n_all : '0;
    pop    = (cnt_q > CW'(NOUT)) ? CW'(NOUT) : cnt_q;
    cnt_d  = cnt_q + n_push - pop;
    wr_d   = wr_q + n_push[AW-1:0];
    rd_d   = rd_q + pop[AW-1:0];
    ovf_d  = ovf_q | (((|in_valid) | excp_in_valid) & ~in_ready);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (acc) begin
      for (int i = 0; i < NCOMMIT; i++) begin
        if (in_valid[i]) begin
          mem_q[waddr[i]] <= '{
            pc:    in_pc[64*i +: 64],
            instr: in_instr[32*i +: 32],
            wen:   in_wen[i],
            wdest: in_wdest[8*i +: 8],
            wdata: in_wdata[64*i +: 64]
          };
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= '0;
      for (int k = 0; k < NOUT; k++) ent_q[k] <= '0;
    end else begin
      for (int k = 0; k < NOUT; k++) begin
        if (CW'(k) < pop) begin
          vld_q[k] <= 1'b1;
          ent_q[k] <= mem_q[rd_q + AW'(k)];
        end else begin
          vld_q[k] <= 1'b0;
          ent_q[k] <= '0;
        end
      end
    end
  end

  for (genvar k = 0; k < NOUT; k++) begin : g_out
    assign out_pc[64*k +: 64]    = ent_q[k].pc;
    assign out_instr[32*k +: 32] = ent_q[k].instr;
    assign out_wen[k]            = ent_q[k].wen;
    assign out_wdest[8*k +: 8]   = ent_q[k].wdest;
    assign out_wdata[64*k +: 64] = ent_q[k].wdata;
    assign out_index[8*k +: 8]   = vld_q[k] ? 8'(k) : 8'h00;
  end
  assign out_valid = vld_q;

  always_ff @(posedge clock) begin
    if (reset) st_q <= EX_IDLE;
    else       st_q <= st_d;
  end

  // Fire once the last older commit leaves the FIFO on this edge.
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      EX_IDLE: if (acc && excp_in_valid)
                 st_d = (cnt_d == '0) ? EX_FIRE : EX_WAIT;
      EX_WAIT: if (cnt_d == '0) st_d = EX_FIRE;
      EX_FIRE: st_d = EX_IDLE;
      default: st_d = EX_IDLE;
    endcase
  end

  always_comb begin
    excp_valid = (st_q == EX_FIRE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      eret_q  <= 1'b0;
      cause_q <= '0;
      epc_q   <= '0;
    end else if (acc && excp_in_valid) begin
      eret_q  <= excp_in_eret;
      cause_q <= excp_in_cause;
      epc_q   <= excp_in_pc;
    end
  end

  assign excp_eret    = eret_q;
  assign excp_cause   = cause_q;
  assign excp_pc      = epc_q;
  assign overflow_err = ovf_q;

endmodule
